// File: rtl/game_flow_ctrl.sv
// Duck-hunt game sequencer: screen state, duck flight/shot timing, round pass/fail, game over.
// Optional pause feature enabled by defining GAME_PAUSE_EN.
module game_flow_ctrl #(
  parameter int unsigned SHOTS_PER_DUCK  = 3,
  parameter int unsigned DUCKS_PER_ROUND = 10,
  parameter int unsigned PASS_HITS       = 6,
  parameter int unsigned DUCK_FRAMES     = 300,
  parameter int unsigned GAP_FRAMES      = 60,
  parameter int unsigned OVER_FRAMES     = 180
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       trigger,
  input  logic       hit,
  input  logic       pause,
  output logic [1:0] state,
  output logic       duck_launch,
  output logic       duck_active,
  output logic [1:0] shots_left,
  output logic [3:0] ducks_left,
  output logic [3:0] hits,
  output logic [3:0] round,
  output logic [7:0] score,
  output logic       paused
);

  localparam logic [2:0] StTitle    = 3'd0;
  localparam logic [2:0] StLaunch   = 3'd1;
  localparam logic [2:0] StFly      = 3'd2;
  localparam logic [2:0] StGap      = 3'd3;
  localparam logic [2:0] StRoundEnd = 3'd4;
  localparam logic [2:0] StOver     = 3'd5;

  localparam logic [1:0] ShotsInit = 2'(SHOTS_PER_DUCK);
  localparam logic [3:0] DucksInit = 4'(DUCKS_PER_ROUND);
  localparam logic [3:0] PassHits  = 4'(PASS_HITS);
  localparam logic [9:0] DuckLast  = 10'(DUCK_FRAMES - 1);
  localparam logic [9:0] GapLast   = 10'(GAP_FRAMES - 1);
  localparam logic [9:0] OverLast  = 10'(OVER_FRAMES - 1);

  logic [2:0] fsm_q, fsm_d;
  logic [9:0] cnt_q, cnt_d;
  logic [1:0] shots_q, shots_d;
  logic [3:0] ducks_q, ducks_d;
  logic [3:0] hits_q, hits_d;
  logic [3:0] round_q, round_d;
  logic [7:0] score_q, score_d;
  logic       paused_q, paused_d;
  logic [1:0] state_q, state_d;
  logic       launch_q, launch_d;
  logic       active_q, active_d;
  logic       start_prev_q, trig_prev_q;
  logic       start_edge, trig_edge, frozen, tick_v, trig_v, hit_v;

  assign start_edge = start & ~start_prev_q;
  assign trig_edge  = trigger & ~trig_prev_q;

`ifdef GAME_PAUSE_EN
  logic pause_prev_q, pause_edge;
  assign pause_edge = pause & ~pause_prev_q;
  assign frozen     = paused_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pause_prev_q <= 1'b0;
    else       pause_prev_q <= pause;
  end
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign frozen       = 1'b0;
`endif

  assign tick_v = frame_tick & ~frozen;
  assign trig_v = trig_edge & ~frozen;
  assign hit_v  = hit & ~frozen;

  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    shots_d  = shots_q;
    ducks_d  = ducks_q;
    hits_d   = hits_q;
    round_d  = round_q;
    score_d  = score_q;
    paused_d = paused_q;

    case (fsm_q)
      StTitle: begin
        if (start_edge) begin
          fsm_d   = StLaunch;
          score_d = 8'd0;
          round_d = 4'd1;
          hits_d  = 4'd0;
          ducks_d = DucksInit;
        end
      end
      StLaunch: begin
        if (!frozen) fsm_d = StFly;
      end
      StFly: begin
        if (tick_v) cnt_d = cnt_q + 10'd1;
        if (trig_v && shots_q != 2'd0) shots_d = shots_q - 2'd1;
        if (hit_v) begin
          hits_d  = hits_q + 4'd1;
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          fsm_d   = StGap;
        end else if (trig_v && shots_q == 2'd1) begin
          fsm_d = StGap;
        end else if (tick_v && cnt_q == DuckLast) begin
          fsm_d = StGap;
        end
      end
      StGap: begin
        if (tick_v) begin
          if (cnt_q == GapLast) fsm_d = (ducks_q == 4'd0) ? StRoundEnd : StLaunch;
          else                  cnt_d = cnt_q + 10'd1;
        end
      end
      StRoundEnd: begin
        if (hits_q >= PassHits) begin
          round_d = (round_q == 4'hF) ? round_q : round_q + 4'd1;
          hits_d  = 4'd0;
          ducks_d = DucksInit;
          fsm_d   = StLaunch;
        end else begin
          fsm_d = StOver;
        end
      end
      StOver: begin
        if (tick_v) begin
          if (cnt_q == OverLast) fsm_d = StTitle;
          else                   cnt_d = cnt_q + 10'd1;
        end
      end
      default: fsm_d = StTitle;
    endcase

    // Every state entry restarts the shared frame counter.
    if (fsm_d != fsm_q) cnt_d = 10'd0;
    if (fsm_d == StLaunch && fsm_q != StLaunch) shots_d = ShotsInit;
    if (fsm_d == StGap && fsm_q != StGap) ducks_d = ducks_q - 4'd1;

`ifdef GAME_PAUSE_EN
    if (pause_edge && (fsm_q == StLaunch || fsm_q == StFly || fsm_q == StGap)) begin
      paused_d = ~paused_q;
    end
`endif
    if (fsm_d == StOver) paused_d = 1'b0;

    case (fsm_d)
      StTitle: state_d = 2'b00;
      StOver:  state_d = 2'b10;
      default: state_d = 2'b01;
    endcase
    launch_d = (fsm_d == StLaunch) && (fsm_q != StLaunch);
    active_d = (fsm_d == StFly) && !paused_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fsm_q        <= StTitle;
      cnt_q        <= 10'd0;
      shots_q      <= 2'd0;
      ducks_q      <= 4'd0;
      hits_q       <= 4'd0;
      round_q      <= 4'd0;
      score_q      <= 8'd0;
      paused_q     <= 1'b0;
      state_q      <= 2'b00;
      launch_q     <= 1'b0;
      active_q     <= 1'b0;
      start_prev_q <= 1'b0;
      trig_prev_q  <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      cnt_q        <= cnt_d;
      shots_q      <= shots_d;
      ducks_q      <= ducks_d;
      hits_q       <= hits_d;
      round_q      <= round_d;
      score_q      <= score_d;
      paused_q     <= paused_d;
      state_q      <= state_d;
      launch_q     <= launch_d;
      active_q     <= active_d;
      start_prev_q <= start;
      trig_prev_q  <= trigger;
    end
  end

  assign state       = state_q;
  assign duck_launch = launch_q;
  assign duck_active = active_q;
  assign shots_left  = shots_q;
  assign ducks_left  = ducks_q;
  assign hits        = hits_q;
  assign round       = round_q;
  assign score       = score_q;
  assign paused      = paused_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl with small timing parameters.
module tb_game_flow_ctrl;

  logic       Clk, Reset, frame_tick, start, trigger, hit, pause;
  logic [1:0] state, shots_left;
  logic       duck_launch, duck_active, paused;
  logic [3:0] ducks_left, hits, round;
  logic [7:0] score;

  int n_total = 0;
  int n_bad   = 0;

  game_flow_ctrl #(
    .SHOTS_PER_DUCK (3),
    .DUCKS_PER_ROUND(2),
    .PASS_HITS      (1),
    .DUCK_FRAMES    (4),
    .GAP_FRAMES     (2),
    .OVER_FRAMES    (3)
  ) u_dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .start      (start),
    .trigger    (trigger),
    .hit        (hit),
    .pause      (pause),
    .state      (state),
    .duck_launch(duck_launch),
    .duck_active(duck_active),
    .shots_left (shots_left),
    .ducks_left (ducks_left),
    .hits       (hits),
    .round      (round),
    .score      (score),
    .paused     (paused)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  task automatic shoot();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_state"}, 32'(state), 0);
    check_val({tag, "_launch"}, 32'(duck_launch), 0);
    check_val({tag, "_active"}, 32'(duck_active), 0);
    check_val({tag, "_shots"}, 32'(shots_left), 0);
    check_val({tag, "_ducks"}, 32'(ducks_left), 0);
    check_val({tag, "_hits"}, 32'(hits), 0);
    check_val({tag, "_round"}, 32'(round), 0);
    check_val({tag, "_score"}, 32'(score), 0);
    check_val({tag, "_paused"}, 32'(paused), 0);
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; start = 1'b0; trigger = 1'b0; hit = 1'b0; pause = 1'b0;
    step();
    step();
    check_all_zero("rst");
    Reset = 1'b0;
    step();

    // Round 1, duck 1: launch and hit
    press_start();
    check_val("start_state", 32'(state), 1);
    check_val("start_launch", 32'(duck_launch), 1);
    check_val("start_shots", 32'(shots_left), 3);
    check_val("start_ducks", 32'(ducks_left), 2);
    check_val("start_round", 32'(round), 1);
    step();
    check_val("fly_launch_off", 32'(duck_launch), 0);
    check_val("fly_active", 32'(duck_active), 1);
    hit = 1'b1;
    step();
    hit = 1'b0;
    check_val("hit_hits", 32'(hits), 1);
    check_val("hit_score", 32'(score), 1);
    check_val("hit_active", 32'(duck_active), 0);
    check_val("hit_ducks", 32'(ducks_left), 1);
    tick(1);
    check_val("gap1_launch", 32'(duck_launch), 0);
    tick(1);
    check_val("gap2_launch", 32'(duck_launch), 1);
    check_val("gap2_shots", 32'(shots_left), 3);
    step();

    // Round 1, duck 2: three misses
    shoot();
    check_val("miss1_shots", 32'(shots_left), 2);
    shoot();
    check_val("miss2_shots", 32'(shots_left), 1);
    check_val("miss2_active", 32'(duck_active), 1);
    shoot();
    check_val("miss3_shots", 32'(shots_left), 0);
    check_val("miss3_active", 32'(duck_active), 0);
    check_val("miss3_ducks", 32'(ducks_left), 0);
    shoot();
    check_val("gap_trig_shots", 32'(shots_left), 0);
    check_val("gap_trig_ducks", 32'(ducks_left), 0);
    check_val("gap_trig_score", 32'(score), 1);
    tick(2);
    check_val("rend_round", 32'(round), 1);
    check_val("rend_state", 32'(state), 1);
    step();
    check_val("pass_round", 32'(round), 2);
    check_val("pass_hits", 32'(hits), 0);
    check_val("pass_ducks", 32'(ducks_left), 2);
    check_val("pass_launch", 32'(duck_launch), 1);
    step();

    // Round 2, duck 1: hit and last trigger on the same cycle
    shoot();
    shoot();
    check_val("r2_shots1", 32'(shots_left), 1);
    hit = 1'b1;
    trigger = 1'b1;
    step();
    hit = 1'b0;
    trigger = 1'b0;
    check_val("hit_trig_score", 32'(score), 2);
    check_val("hit_trig_hits", 32'(hits), 1);
    check_val("hit_trig_shots", 32'(shots_left), 0);
    check_val("hit_trig_ducks", 32'(ducks_left), 1);
    step();
    tick(2);

    // Round 2, duck 2: escape after four ticks
    step();
    tick(3);
    check_val("esc3_active", 32'(duck_active), 1);
    tick(1);
    check_val("esc4_active", 32'(duck_active), 0);
    check_val("esc4_ducks", 32'(ducks_left), 0);
    tick(2);
    step();
    check_val("r3_round", 32'(round), 3);
    check_val("r3_hits", 32'(hits), 0);

    // Round 3: both ducks escape, round fails
    step();
    tick(4);
    tick(2);
    step();
    tick(4);
    tick(2);
    check_val("fail_rend_state", 32'(state), 1);
    step();
    check_val("over_state", 32'(state), 2);
    check_val("over_score", 32'(score), 2);
    press_start();
    step();
    check_val("over_start_ignored", 32'(state), 2);
    tick(2);
    check_val("over_hold", 32'(state), 2);
    tick(1);
    check_val("title_state", 32'(state), 0);
    check_val("title_score", 32'(score), 2);
    check_val("title_round", 32'(round), 3);

    // New game, then reset mid-flight
    press_start();
    check_val("restart_score", 32'(score), 0);
    check_val("restart_round", 32'(round), 1);
    step();
    check_val("restart_active", 32'(duck_active), 1);
    Reset = 1'b1;
    #1;
    check_all_zero("midrst");
    step();
    Reset = 1'b0;
    step();
    check_val("post_rst_launch", 32'(duck_launch), 0);

    press_start();
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
`ifdef GAME_PAUSE_EN
    check_val("pause_on", 32'(paused), 1);
    check_val("pause_active", 32'(duck_active), 0);
    tick(10);
    check_val("pause_state", 32'(state), 1);
    check_val("pause_frozen_active", 32'(duck_active), 0);
    pause = 1'b1;
    step();
    pause = 1'b0;
    check_val("pause_off", 32'(paused), 0);
    check_val("unpause_active", 32'(duck_active), 1);
    tick(3);
    check_val("unpause_esc3", 32'(duck_active), 1);
    tick(1);
    check_val("unpause_esc4", 32'(duck_active), 0);
`else
    check_val("nopause_paused", 32'(paused), 0);
    check_val("nopause_active", 32'(duck_active), 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
